hs_arbiter: RTL

//  Round-robin scheduler sharing one hard-swish segment (Q.9 fixed point, 5-cycle en->valid latency) among NUM_REQ requesters (e.g. PE columns).

---
 rtl/hs_arb_pkg.sv | 18 +
 rtl/hs_arb_tag_fifo.sv | 56 +++++
 rtl/hs_arbiter.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/hs_arb_pkg.sv
// Shared constants and types for the hard-swish segment round-robin arbiter.
package hs_arb_pkg;

    localparam int unsigned HS_LAT       = 5;
    localparam int unsigned HS_FRAC_BITS = 9;
    localparam int          HS_THREE     = 1536;
    localparam int unsigned MAX_REQ      = 16;

    function automatic int unsigned id_width(input int unsigned n);
        int unsigned w;
        w = $clog2(n);
        return (w < 1) ? 1 : w;
    endfunction

    // Wide enough for any supported requester count.
    typedef logic [id_width(MAX_REQ)-1:0] tag_t;

endpackage

// File: rtl/hs_arb_tag_fifo.sv
// In-flight requester-ID FIFO: records the owner of each sample issued to the segment.
module hs_arb_tag_fifo
    import hs_arb_pkg::*;
#(
    parameter int unsigned TAG_DEPTH = 8
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  tag_t push_tag,
    input  logic pop,
    output tag_t pop_tag,
    output logic full,
    output logic empty
);

    localparam int unsigned PtrW = $clog2(TAG_DEPTH);
    localparam int unsigned CntW = $clog2(TAG_DEPTH + 1);

    tag_t            mem_q [TAG_DEPTH];
    logic [PtrW-1:0] wr_q;
    logic [PtrW-1:0] rd_q;
    logic [CntW-1:0] cnt_q;
    logic [PtrW-1:0] wr_nxt;
    logic [PtrW-1:0] rd_nxt;

    always_comb begin
        wr_nxt = (wr_q == PtrW'(TAG_DEPTH - 1)) ? '0 : wr_q + PtrW'(1);
        rd_nxt = (rd_q == PtrW'(TAG_DEPTH - 1)) ? '0 : rd_q + PtrW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_q  <= '0;
            rd_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (push) wr_q <= wr_nxt;
            if (pop)  rd_q <= rd_nxt;
            unique case ({push, pop})
                2'b10:   cnt_q <= cnt_q + CntW'(1);
                2'b01:   cnt_q <= cnt_q - CntW'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_q] <= push_tag;
    end

    assign pop_tag = mem_q[rd_q];
    assign full    = (cnt_q == CntW'(TAG_DEPTH));
    assign empty   = (cnt_q == '0);

endmodule

// File: rtl/hs_arbiter.sv
// Round-robin scheduler sharing one hard-swish segment among NUM_REQ requesters.
// Define HS_ARB_LOCK_EN to hold the grant on a requester until its burst's last sample.
module hs_arbiter
    import hs_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned OUT_SIZE   = 18,
    parameter int unsigned TAG_DEPTH  = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ-1:0]            req_last,
    output logic [NUM_REQ-1:0]            req_ready,
    output logic                          hs_en,
    output logic [DATA_WIDTH-1:0]         hs_data,
    input  logic                          hs_valid,
    input  logic [OUT_SIZE-1:0]           hs_result,
    output logic [NUM_REQ-1:0]            rsp_valid,
    output logic [OUT_SIZE-1:0]           rsp_data,
    output logic                          busy,
    output logic                          err_orphan
);

    localparam int unsigned IdW = id_width(NUM_REQ);

    logic [IdW-1:0]        ptr_q, ptr_d, ptr_inc;
    logic [IdW-1:0]        gnt_id, idx;
    logic                  gnt_any;
    logic [DATA_WIDTH-1:0] gnt_data;
    logic                  hs_en_q;
    logic [DATA_WIDTH-1:0] hs_data_q;
    logic [NUM_REQ-1:0]    rsp_valid_q, rsp_valid_d;
    logic [OUT_SIZE-1:0]   rsp_data_q;
    logic                  err_q;
    logic                  fifo_full, fifo_empty, pop, orphan;
    tag_t                  pop_tag;

`ifdef HS_ARB_LOCK_EN
    logic           lock_q, lock_d;
    logic [IdW-1:0] lock_id_q, lock_id_d;
`else
    logic unused_last;
    assign unused_last = ^req_last;
`endif

    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        idx     = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            idx = IdW'((32'(ptr_q) + k) % NUM_REQ);
            if (!gnt_any && req_valid[idx]) begin
                gnt_any = 1'b1;
                gnt_id  = idx;
            end
        end
`ifdef HS_ARB_LOCK_EN
        // Mid-burst: only the locked owner may transfer; a gap in its valid stalls everyone.
        if (lock_q) begin
            gnt_any = req_valid[lock_id_q];
            gnt_id  = lock_id_q;
        end
`endif
        if (rst || fifo_full) gnt_any = 1'b0;
    end

    always_comb begin
        req_ready = '0;
        if (gnt_any) req_ready = NUM_REQ'(1) << gnt_id;
        gnt_data = req_data[gnt_id*DATA_WIDTH +: DATA_WIDTH];
        ptr_inc  = (gnt_id == IdW'(NUM_REQ - 1)) ? '0 : gnt_id + IdW'(1);
        ptr_d    = ptr_q;
`ifdef HS_ARB_LOCK_EN
        lock_d    = lock_q;
        lock_id_d = lock_id_q;
        if (gnt_any) begin
            if (req_last[gnt_id]) begin
                lock_d = 1'b0;
                ptr_d  = ptr_inc;
            end else begin
                lock_d    = 1'b1;
                lock_id_d = gnt_id;
            end
        end
`else
        if (gnt_any) ptr_d = ptr_inc;
`endif
    end

    assign pop    = hs_valid & ~fifo_empty;
    assign orphan = hs_valid & fifo_empty;

    always_comb begin
        rsp_valid_d = '0;
        if (pop) rsp_valid_d = NUM_REQ'(1) << pop_tag;
    end

    hs_arb_tag_fifo #(
        .TAG_DEPTH(TAG_DEPTH)
    ) u_tag_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (gnt_any),
        .push_tag(tag_t'(gnt_id)),
        .pop     (pop),
        .pop_tag (pop_tag),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q       <= '0;
            hs_en_q     <= 1'b0;
            hs_data_q   <= '0;
            rsp_valid_q <= '0;
            rsp_data_q  <= '0;
            err_q       <= 1'b0;
        end else begin
            ptr_q       <= ptr_d;
            hs_en_q     <= gnt_any;
            rsp_valid_q <= rsp_valid_d;
            if (gnt_any) hs_data_q  <= gnt_data;
            if (pop)     rsp_data_q <= hs_result;
            if (orphan)  err_q      <= 1'b1;
        end
    end

`ifdef HS_ARB_LOCK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            lock_q    <= 1'b0;
            lock_id_q <= '0;
        end else begin
            lock_q    <= lock_d;
            lock_id_q <= lock_id_d;
        end
    end
`endif

    assign hs_en      = hs_en_q;
    assign hs_data    = hs_data_q;
    assign rsp_valid  = rsp_valid_q;
    assign rsp_data   = rsp_data_q;
    assign busy       = ~fifo_empty;
    assign err_orphan = err_q;

endmodule
